// File: rtl/ps2_mouse_cursor_if.sv
// Bundles the raw PS/2 lines and the cursor/status outputs of ps2_mouse_cursor.
// slave = the decoder side, master = the PS/2 source plus display consumer.
interface ps2_mouse_cursor_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           ps2_clk;
  logic           ps2_data;
  logic [X_W-1:0] cursor_x;
  logic [Y_W-1:0] cursor_y;
  logic [2:0]     buttons;
  logic [3:0]     wheel_delta;
  logic           pkt_valid;
  logic           frame_err;

  modport slave (
    input  ps2_clk, ps2_data,
    output cursor_x, cursor_y, buttons, wheel_delta, pkt_valid, frame_err
  );

  modport master (
    output ps2_clk, ps2_data,
    input  cursor_x, cursor_y, buttons, wheel_delta, pkt_valid, frame_err
  );
endinterface

// File: rtl/ps2_mouse_cursor.sv
// Receive-only PS/2 mouse decoder producing a screen-bounded cursor position.
// Define PS2_WHEEL_EN for 4-byte scroll-wheel packets; default is 3-byte packets.
module ps2_mouse_cursor #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic               clk,
  input  logic               rst,
  ps2_mouse_cursor_if.slave  bus
);

  localparam int AW  = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [AW-1:0] X_MAX_S = AW'(X_MAX);
  localparam logic signed [AW-1:0] Y_MAX_S = AW'(Y_MAX);
`ifdef PS2_WHEEL_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       clk_sync, data_sync;
  logic             clk_filt, clk_filt_d;
  logic [FCW-1:0]   filt_cnt;
  logic [TCW-1:0]   tmo_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par_bit;
  logic [1:0]       byte_idx;
  logic [6:0]       hdr;          // {y_ovf, x_ovf, y_sign, x_sign, m, r, l}
  logic [7:0]       b1;
  logic [X_W-1:0]   cursor_x;
  logic [Y_W-1:0]   cursor_y;
  logic [2:0]       buttons;
  logic             pkt_valid, frame_err;

  logic             fall, data_s, byte_done, byte_good, frame_bad, pkt_done, timeout_hit;
  logic [7:0]       y_byte;
  logic [8:0]       dx9, dy9;
  logic signed [AW-1:0] sum_x, sum_y;
  logic [X_W-1:0]   next_x;
  logic [Y_W-1:0]   next_y;

  assign data_s      = data_sync[1];
  assign fall        = clk_filt_d & ~clk_filt;
  assign byte_done   = fall && (state == S_STOP);
  assign byte_good   = byte_done && data_s && (^{shift, par_bit});
  assign frame_bad   = byte_done && !byte_good;
  assign pkt_done    = byte_good && (byte_idx == LAST_IDX);
  assign timeout_hit = (tmo_cnt == TCW'(TIMEOUT_CYC)) && (state != S_IDLE || byte_idx != 2'd0);

  // Input conditioning: synchronise, then debounce the clock line.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the synchroniser chain.
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], bus.ps2_clk};
      data_sync  <= {data_sync[0], bus.ps2_data};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FCW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; a missing branch would otherwise infer a latch.
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!data_s) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Movement decode: the final byte of a packet is still in the shifter.
`ifdef PS2_WHEEL_EN
  logic [7:0] b2;
  logic [3:0] wheel_delta;
  assign y_byte = b2;
`else
  assign y_byte = shift;
`endif

  always_comb begin
    dx9    = hdr[5] ? 9'd0 : {hdr[3], b1};
    dy9    = hdr[6] ? 9'd0 : {hdr[4], y_byte};
    sum_x  = AW'({1'b0, cursor_x}) + {{(AW-9){dx9[8]}}, dx9};
    sum_y  = AW'({1'b0, cursor_y}) - {{(AW-9){dy9[8]}}, dy9};
    next_x = sum_x[AW-1] ? '0 : (sum_x > X_MAX_S) ? X_W'(X_MAX) : sum_x[X_W-1:0];
    next_y = sum_y[AW-1] ? '0 : (sum_y > Y_MAX_S) ? Y_W'(Y_MAX) : sum_y[Y_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      byte_idx  <= 2'd0;
      hdr       <= '0;
      b1        <= '0;
      cursor_x  <= X_W'(X_MAX / 2);
      cursor_y  <= Y_W'(Y_MAX / 2);
      buttons   <= 3'b000;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef PS2_WHEEL_EN
      b2          <= '0;
      wheel_delta <= 4'd0;
`endif
    end else begin
      state     <= state_nxt;
      pkt_valid <= pkt_done;
      frame_err <= frame_bad;

      if (fall) tmo_cnt <= '0;
      else if (tmo_cnt != TCW'(TIMEOUT_CYC)) tmo_cnt <= tmo_cnt + TCW'(1);

      if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= 3'd0;
          S_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= data_s;
          default:  ;
        endcase
      end

      if (timeout_hit || frame_bad || pkt_done) begin
        byte_idx <= 2'd0;
      end else if (byte_good) begin
        case (byte_idx)
          2'd0: if (shift[3]) begin
            hdr      <= {shift[7:4], shift[2:0]};
            byte_idx <= 2'd1;
          end
          2'd1: begin
            b1       <= shift;
            byte_idx <= 2'd2;
          end
`ifdef PS2_WHEEL_EN
          2'd2: begin
            b2       <= shift;
            byte_idx <= 2'd3;
          end
`endif
          default: byte_idx <= 2'd0;
        endcase
      end

      if (pkt_done) begin
        cursor_x <= next_x;
        cursor_y <= next_y;
        buttons  <= hdr[2:0];
`ifdef PS2_WHEEL_EN
        wheel_delta <= shift[3:0];
`endif
      end
    end
  end

  assign bus.cursor_x  = cursor_x;
  assign bus.cursor_y  = cursor_y;
  assign bus.buttons   = buttons;
  assign bus.pkt_valid = pkt_valid;
  assign bus.frame_err = frame_err;
`ifdef PS2_WHEEL_EN
  assign bus.wheel_delta = wheel_delta;
`else
  assign bus.wheel_delta = 4'd0;
`endif

endmodule
